// File: rtl/timer_counter.sv
// 8051-style timer/counter: prescaled tick or synchronised pin events drive 13/16/8-reload/split counts.
// Define TIMER_SPLIT_MODE_EN to enable the split mode (11); otherwise mode 11 holds both bytes.
module timer_counter #(
    parameter int unsigned     PRESCALE      = 12,
    parameter logic [7:0]      RELOAD_ON_RST = 8'h00
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_byte,
    input  logic       i_wr_lo,
    input  logic       i_wr_hi,
    input  logic [1:0] i_mode,
    input  logic       i_ct,
    input  logic       i_run,
    input  logic       i_gate,
    input  logic       i_int_n,
    input  logic       i_run_hi,
    input  logic       i_t_pin,
    output logic [7:0] o_lo,
    output logic [7:0] o_hi,
    output logic       o_ovf,
    output logic       o_ovf_hi
);

    localparam logic [7:0] PRESC_LAST = 8'(PRESCALE - 1);

    logic [7:0]  presc_q, presc_d;
    logic        pin_meta_q, pin_meta_d;
    logic        pin_sync_q, pin_sync_d;
    logic        pin_prev_q, pin_prev_d;
    logic [7:0]  lo_q, lo_d;
    logic [7:0]  hi_q, hi_d;
    logic        ovf_q, ovf_d;
    logic        ovf_hi_q, ovf_hi_d;

    logic        tick;
    logic        pin_fall;
    logic        evt;
    logic [12:0] cnt13_inc;
    logic        cnt13_full;
    logic [15:0] cnt16_inc;
    logic        cnt16_full;
    logic [7:0]  lo_inc;

    assign tick       = (presc_q == PRESC_LAST);
    assign pin_fall   = pin_prev_q & ~pin_sync_q;
    assign evt        = (i_ct ? pin_fall : tick) & i_run & (~i_gate | i_int_n);
    assign cnt13_inc  = {hi_q, lo_q[4:0]} + 13'd1;
    assign cnt13_full = ({hi_q, lo_q[4:0]} == 13'h1FFF);
    assign cnt16_inc  = {hi_q, lo_q} + 16'd1;
    assign cnt16_full = ({hi_q, lo_q} == 16'hFFFF);
    assign lo_inc     = lo_q + 8'd1;

`ifndef TIMER_SPLIT_MODE_EN
    logic unused_run_hi;
    assign unused_run_hi = i_run_hi;
`endif

    always_comb begin
        presc_d    = tick ? 8'd0 : presc_q + 8'd1;
        pin_meta_d = i_t_pin;
        pin_sync_d = pin_meta_q;
        pin_prev_d = pin_sync_q;
    end

    always_comb begin
        lo_d     = lo_q;
        hi_d     = hi_q;
        ovf_d    = 1'b0;
        ovf_hi_d = 1'b0;
        case (i_mode)
            2'b00: begin
                if (evt) begin
                    lo_d  = {lo_q[7:5], cnt13_inc[4:0]};
                    hi_d  = cnt13_inc[12:5];
                    ovf_d = cnt13_full;
                end
            end
            2'b01: begin
                if (evt) begin
                    {hi_d, lo_d} = cnt16_inc;
                    ovf_d        = cnt16_full;
                end
            end
            2'b10: begin
                if (evt) begin
                    if (lo_q == 8'hFF) begin
                        lo_d  = hi_q;
                        ovf_d = 1'b1;
                    end else begin
                        lo_d  = lo_inc;
                    end
                end
            end
            default: begin
`ifdef TIMER_SPLIT_MODE_EN
                if (evt) begin
                    lo_d  = lo_inc;
                    ovf_d = (lo_q == 8'hFF);
                end
                if (tick && i_run_hi) begin
                    hi_d     = hi_q + 8'd1;
                    ovf_hi_d = (hi_q == 8'hFF);
                end
`endif
            end
        endcase

        // A write wins over the increment; in the linked modes it also swallows the carry.
        if (i_wr_lo) begin
            lo_d = i_byte;
            if (!i_mode[1]) begin
                hi_d = hi_q;
            end
        end
        if (i_wr_hi) begin
            hi_d = i_byte;
        end
        if (i_mode == 2'b11) begin
            if (i_wr_lo) ovf_d = 1'b0;
            if (i_wr_hi) ovf_hi_d = 1'b0;
        end else if (i_wr_lo || i_wr_hi) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            presc_q    <= 8'd0;
            pin_meta_q <= 1'b1;
            pin_sync_q <= 1'b1;
            pin_prev_q <= 1'b1;
            lo_q       <= RELOAD_ON_RST;
            hi_q       <= RELOAD_ON_RST;
            ovf_q      <= 1'b0;
            ovf_hi_q   <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            pin_meta_q <= pin_meta_d;
            pin_sync_q <= pin_sync_d;
            pin_prev_q <= pin_prev_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            ovf_q      <= ovf_d;
            ovf_hi_q   <= ovf_hi_d;
        end
    end

    assign o_lo     = lo_q;
    assign o_hi     = hi_q;
    assign o_ovf    = ovf_q;
    assign o_ovf_hi = ovf_hi_q;

endmodule

// File: tb/tb_timer_counter.sv
// Directed scoreboard bench for timer_counter (PRESCALE=12): expected snapshots and overflow pulses queued, monitor pops.
`timescale 1ns/1ps
module tb_timer_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] byte_in = 8'h00;
    logic       wr_lo = 1'b0, wr_hi = 1'b0;
    logic [1:0] mode = 2'b01;
    logic       ct = 1'b0, run = 1'b1, gate = 1'b0, int_n = 1'b1, run_hi = 1'b0, t_pin = 1'b1;
    logic [7:0] o_lo, o_hi;
    logic       o_ovf, o_ovf_hi;

    timer_counter dut (
        .i_clk(clk), .i_rst(rst), .i_byte(byte_in), .i_wr_lo(wr_lo), .i_wr_hi(wr_hi),
        .i_mode(mode), .i_ct(ct), .i_run(run), .i_gate(gate), .i_int_n(int_n),
        .i_run_hi(run_hi), .i_t_pin(t_pin), .o_lo(o_lo), .o_hi(o_hi),
        .o_ovf(o_ovf), .o_ovf_hi(o_ovf_hi)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        bit         is_hi;
        int         cyc;
        logic [7:0] lo;
        logic [7:0] hi;
    } exp_t;

    exp_t snap_q[$];
    exp_t ovf_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   r = 0;
    logic snap = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: checks a snapshot when requested and every overflow pulse the DUT presents.
    always @(negedge clk) begin
        exp_t e;
        if (snap) begin
            total++;
            if (snap_q.size() == 0) begin
                bad++;
                $display("FAIL snap_underflow: no expected snapshot queued");
            end else begin
                e = snap_q.pop_front();
                if (o_lo !== e.lo || o_hi !== e.hi) begin
                    bad++;
                    $display("FAIL %s: got lo=%h hi=%h, expected lo=%h hi=%h", e.name, o_lo, o_hi, e.lo, e.hi);
                end
            end
        end
        if (o_ovf || o_ovf_hi) begin
            total++;
            if (ovf_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_ovf: ovf=%b ovf_hi=%b at cycle %0d lo=%h hi=%h", o_ovf, o_ovf_hi, cyc - r, o_lo, o_hi);
            end else begin
                e = ovf_q.pop_front();
                if (o_ovf !== !e.is_hi || o_ovf_hi !== e.is_hi || cyc != e.cyc || o_lo !== e.lo || o_hi !== e.hi) begin
                    bad++;
                    $display("FAIL %s: got ovf=%b ovf_hi=%b cyc=%0d lo=%h hi=%h, expected ovf=%b ovf_hi=%b cyc=%0d lo=%h hi=%h",
                             e.name, o_ovf, o_ovf_hi, cyc - r, o_lo, o_hi, !e.is_hi, e.is_hi, e.cyc - r, e.lo, e.hi);
                end
            end
        end
    end

    task automatic step1();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_j(input int j);
        while (cyc - r < j) step1();
    endtask

    task automatic wr(input bit lo_en, input bit hi_en, input logic [7:0] b, input int j);
        goto_j(j - 1);
        wr_lo = lo_en;
        wr_hi = hi_en;
        byte_in = b;
        step1();
        wr_lo = 1'b0;
        wr_hi = 1'b0;
    endtask

    task automatic snap_at(input int j, input string nm, input logic [7:0] lo, input logic [7:0] hi);
        exp_t e;
        goto_j(j);
        e.name = nm; e.is_hi = 1'b0; e.cyc = -1; e.lo = lo; e.hi = hi;
        snap_q.push_back(e);
        snap = 1'b1;
        @(negedge clk);
        #1;
        snap = 1'b0;
    endtask

    task automatic expect_ovf(input string nm, input bit is_hi, input int j, input logic [7:0] lo, input logic [7:0] hi);
        exp_t e;
        e.name = nm; e.is_hi = is_hi; e.cyc = r + j; e.lo = lo; e.hi = hi;
        ovf_q.push_back(e);
    endtask

    task automatic pin_pulses(input int n);
        repeat (n) begin
            t_pin = 1'b0;
            repeat (3) step1();
            t_pin = 1'b1;
            repeat (3) step1();
        end
        repeat (4) step1();
    endtask

    function automatic int next_tick();
        return ((cyc - r + 3 + 11) / 12) * 12;
    endfunction

    initial begin
        int nt;
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        int nt;
        snap_at(0, "reset_state", 8'h00, 8'h00);
        step1();
        rst = 1'b0;
        r = cyc;

        // 16-bit: write hi=FF, lo=FE (on a tick edge, increment suppressed); wrap 24 cycles after lo write
        wr(1'b0, 1'b1, 8'hFF, 11);
        wr(1'b1, 1'b0, 8'hFE, 12);
        expect_ovf("ovf_16bit", 1'b0, 36, 8'h00, 8'h00);
        snap_at(24, "m01_ffff", 8'hFF, 8'hFF);
        snap_at(37, "m01_wrapped", 8'h00, 8'h00);

        // Write on the tick edge with lo=FF hi=FF: write wins, no carry, no overflow
        wr(1'b1, 1'b0, 8'hFF, 38);
        wr(1'b0, 1'b1, 8'hFF, 39);
        wr(1'b1, 1'b0, 8'h10, 48);
        snap_at(48, "wr_priority", 8'h10, 8'hFF);
        snap_at(60, "m01_inc", 8'h11, 8'hFF);
        wr(1'b0, 1'b1, 8'h00, 61);
        wr(1'b1, 1'b0, 8'hFF, 62);
        snap_at(72, "m01_carry", 8'h00, 8'h01);

        // 8-bit auto-reload
        mode = 2'b10;
        wr(1'b0, 1'b1, 8'h9C, 73);
        wr(1'b1, 1'b0, 8'hFF, 74);
        expect_ovf("ovf_reload", 1'b0, 84, 8'h9C, 8'h9C);
        snap_at(85, "m10_reload", 8'h9C, 8'h9C);
        snap_at(96, "m10_inc", 8'h9D, 8'h9C);

        // 13-bit: upper lo bits hold through the wrap
        mode = 2'b00;
        wr(1'b0, 1'b1, 8'hFF, 97);
        wr(1'b1, 1'b0, 8'hBF, 98);
        expect_ovf("ovf_13bit", 1'b0, 108, 8'hA0, 8'h00);
        snap_at(108, "m00_wrap", 8'hA0, 8'h00);
        snap_at(120, "m00_inc", 8'hA1, 8'h00);
        wr(1'b1, 1'b0, 8'h5F, 121);
        snap_at(132, "m00_carry", 8'h40, 8'h01);

        // run low freezes; prescaler phase unaffected
        run = 1'b0;
        snap_at(145, "run_frozen", 8'h40, 8'h01);
        run = 1'b1;
        snap_at(155, "run_resume_pre", 8'h40, 8'h01);
        snap_at(156, "run_resume_tick", 8'h41, 8'h01);

        // Counter mode with gate: int_n low blocks, int_n high counts each falling edge
        mode = 2'b01; ct = 1'b1; gate = 1'b1; int_n = 1'b0;
        wr(1'b0, 1'b1, 8'h00, 157);
        wr(1'b1, 1'b0, 8'h00, 158);
        pin_pulses(5);
        snap_at(cyc - r, "gate_blocked", 8'h00, 8'h00);
        int_n = 1'b1;
        pin_pulses(5);
        snap_at(cyc - r, "pin_count5", 8'h05, 8'h00);

        // Split mode 11: only hi runs (run=0, run_hi=1)
        ct = 1'b0; gate = 1'b0; run = 1'b0; run_hi = 1'b1; mode = 2'b11;
        nt = next_tick();
        wr(1'b0, 1'b1, 8'hFF, nt - 2);
        wr(1'b1, 1'b0, 8'h33, nt - 1);
`ifdef TIMER_SPLIT_MODE_EN
        expect_ovf("ovf_split_hi", 1'b1, nt, 8'h33, 8'h00);
        snap_at(nt, "split_wrap", 8'h33, 8'h00);
        snap_at(nt + 12, "split_inc", 8'h33, 8'h01);
`else
        snap_at(nt, "m11_hold", 8'h33, 8'hFF);
        snap_at(nt + 12, "m11_hold2", 8'h33, 8'hFF);
`endif

        // Reset asserted in the overflow pulse cycle aborts it without a clock
        mode = 2'b01; run = 1'b1; run_hi = 1'b0;
        nt = next_tick();
        wr(1'b0, 1'b1, 8'hFF, nt - 2);
        wr(1'b1, 1'b0, 8'hFF, nt - 1);
        goto_j(nt);
        rst = 1'b1;
        snap_at(nt, "rst_abort_pulse", 8'h00, 8'h00);
        step1();
        step1();
        rst = 1'b0;
        r = cyc;

        // First tick PRESCALE cycles after release; then async reset clears counts immediately
        snap_at(11, "first_tick_pre", 8'h00, 8'h00);
        snap_at(12, "first_tick", 8'h01, 8'h00);
        wr(1'b1, 1'b0, 8'h5A, 14);
        goto_j(16);
        rst = 1'b1;
        snap_at(16, "rst_async_counts", 8'h00, 8'h00);

        total++;
        if (ovf_q.size() != 0) begin
            bad++;
            $display("FAIL pending_ovf: %0d expected overflow pulses not seen, first=%s", ovf_q.size(), ovf_q[0].name);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 Parameter PRESCALE, default 12, clocks per timer tick (machine cycle); legal range 1..255.
REQ-002 Parameter RELOAD_ON_RST, default 8'h00, reset value of both count bytes.
REQ-003 i_clk  input  1  sole clock, all state on rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_byte  input  8  write data.
REQ-006 i_wr_lo / i_wr_hi  input  1 each  write strobe for low (TLx) / high (THx) byte.
REQ-007 i_mode  input  2  00=13-bit, 01=16-bit, 10=8-bit auto-reload, 11=split.
REQ-008 i_ct  input  1  0=timer (prescaled clock), 1=counter (external pin falling edges).
REQ-009 i_run / i_gate / i_int_n  input  1 each  TRx, GATE, active-low INTx pin.
REQ-010 i_run_hi  input  1  run enable for the high byte in split mode.
REQ-011 i_t_pin  input  1  external count pin, asynchronous.
REQ-012 o_lo / o_hi  output  8 each  current low/high count bytes.
REQ-013 o_ovf / o_ovf_hi  output  1 each  one-cycle overflow pulses (TFx; high-byte TF in split mode).

Function
REQ-014 Prescaler: free-running, wraps at PRESCALE-1; tick = 1 for one cycle at the wrap.
REQ-015 i_t_pin passes a 2-flop synchroniser; edge = (previous sample 1, current sample 0); one event per falling edge, max one per cycle.
REQ-016 Count event = (i_ct ? edge : tick) AND i_run AND (!i_gate OR i_int_n).
REQ-017 Mode 00: 13-bit count = {o_hi[7:0], o_lo[4:0]}; o_lo[7:5] hold; overflow at 0x1FFF->0, both bytes then 0 in the low 13 bits.
REQ-018 Mode 01: 16-bit count {o_hi,o_lo}; overflow at 0xFFFF->0x0000.
REQ-019 Mode 10: o_lo counts; on 0xFF event o_lo loads o_hi, o_hi unchanged, overflow.
REQ-020 Mode 11: o_lo is 8-bit, events per REQ-016, overflow on o_ovf; o_hi is 8-bit timer counting tick AND i_run_hi (no gate, no counter mode), overflow on o_ovf_hi.
REQ-021 Overflow pulse asserted in the cycle after the wrapping edge, exactly one cycle; never on write.
REQ-022 Write priority: a byte write in the same cycle as an event overrides the increment for that byte; carry into the other byte from that event is suppressed; no overflow.
REQ-023 i_wr_lo and i_wr_hi together write both bytes with i_byte.
REQ-024 Mode change takes effect on the next event; count bytes are not altered by a mode change.
REQ-025 i_run low freezes the counts; prescaler keeps running.

Reset
REQ-026 i_rst asserted: o_lo = o_hi = RELOAD_ON_RST, prescaler = 0, synchroniser = 1,1, o_ovf = o_ovf_hi = 0, immediately without clock.
REQ-027 Reset mid-count or mid-pulse aborts it; first tick occurs PRESCALE cycles after release.

Configuration
REQ-028 Macro TIMER_SPLIT_MODE_EN defined: mode 11 per REQ-020.
REQ-029 Macro undefined: mode 11 holds both bytes, o_ovf_hi tied 0, i_run_hi ignored; writes still function.

Verification
REQ-030 Reset, PRESCALE=12, mode 01, run=1, write lo=FE hi=FF -> o_ovf pulses once 24 cycles after write, counts 0x0000.
REQ-031 Mode 10, hi=0x9C, lo=0xFF, run=1 -> next tick lo=0x9C, o_ovf one cycle, hi stays 0x9C.
REQ-032 Mode 00, count 0x1FFF, run -> next tick hi=0x00, lo[4:0]=0, lo[7:5] unchanged, o_ovf pulse.
REQ-033 Counter mode, gate=1, int_n=0 then 1, 5 pin falling edges each -> count advances 0 then 5.
REQ-034 Write lo=0x10 in the tick cycle with lo=0xFF, mode 01 -> lo=0x10, hi unchanged, no o_ovf.
REQ-035 Mode 11 with macro, run=0, run_hi=1, hi=0xFF -> o_ovf_hi pulse next tick, lo frozen; without macro -> no pulse, both bytes hold.
